decode_cycle_stage: RTL and testbench

- Instruction-decode pipeline stage of the 16-bit processor. Sits between fetch and execute.
- Splits the fetched instruction word into register specifiers, an opcode and an immediate.
- Reads two operands from an internal 16x16 register file and registers all decode results for the execute stage.
- Accepts a write port (writedata/regwrite) into the same register file.

---
 rtl/decode_cycle_stage_pkg.sv | 25 ++
 rtl/decode_regfile.sv | 34 +++
 rtl/decode_cycle_stage.sv | 94 +++++++++
 tb/tb_decode_cycle_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_cycle_stage_pkg.sv
// Shared field positions, widths and opcode constants for the decode stage.
// Used by decode_cycle_stage and decode_regfile.
package decode_cycle_stage_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    localparam int RS2_MSB = 15;
    localparam int RS1_MSB = 11;
    localparam int RD_MSB  = 7;
    localparam int OP_MSB  = 3;

    localparam logic [3:0] OP_RTYPE = 4'h0;

    typedef enum logic [0:0] {
        FMT_R = 1'b0,
        FMT_I = 1'b1
    } fmt_t;

    // Every opcode other than the R-type code decodes as I-type.
    function automatic fmt_t decode_fmt(input logic [3:0] op);
        return (op == OP_RTYPE) ? FMT_R : FMT_I;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file for the decode stage: two combinational read ports, one write
// port, reset reloads entry i with value i, entry 0 reads as zero.
module decode_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr1,
    input  logic [3:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (we && (waddr != 4'h0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Entry 0 is masked on read so its stored contents never matter.
    assign rdata1 = (raddr1 == 4'h0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 4'h0) ? '0 : regs[raddr2];

endmodule

// File: rtl/decode_cycle_stage.sv
// Instruction-decode stage: field split, immediate generation, operand read and
// pipeline registers. Define DECODE_WRITE_BYPASS_EN to forward same-cycle writes.
module decode_cycle_stage #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] writedata,
    input  logic              regwrite,
    output logic [DATA_W-1:0] pcout,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [3:0]        rdout,
    output logic [DATA_W-1:0] imm
);

    import decode_cycle_stage_pkg::*;

    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rd;
    logic [3:0]            op;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic [DATA_W-1:0]     anext;
    logic [DATA_W-1:0]     bnext;
    logic [DATA_W-1:0]     immnext;

    assign rs2 = ir[RS2_MSB -: REG_ADDR_W];
    assign rs1 = ir[RS1_MSB -: REG_ADDR_W];
    assign rd  = ir[RD_MSB  -: REG_ADDR_W];
    assign op  = ir[OP_MSB  -: 4];

    decode_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (regwrite),
        .waddr  (rd),
        .wdata  (writedata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always_comb begin
        immnext = '0;
        if (decode_fmt(op) == FMT_I) begin
            immnext = {{(DATA_W-8){ir[15]}}, ir[15:8]};
        end
    end

`ifdef DECODE_WRITE_BYPASS_EN
    // Forward the in-flight write so execute sees the newest value.
    always_comb begin
        anext = rdata1;
        bnext = rdata2;
        if (regwrite && (rd != 4'h0) && (rd == rs1)) begin
            anext = writedata;
        end
        if (regwrite && (rd != 4'h0) && (rd == rs2)) begin
            bnext = writedata;
        end
    end
`else
    always_comb begin
        anext = rdata1;
        bnext = rdata2;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcout <= '0;
            a     <= '0;
            b     <= '0;
            rdout <= '0;
            imm   <= '0;
        end else begin
            pcout <= pc;
            a     <= anext;
            b     <= bnext;
            rdout <= rd;
            imm   <= immnext;
        end
    end

endmodule

// File: tb/tb_decode_cycle_stage.sv
// Self-checking bench for decode_cycle_stage: directed vectors plus random
// traffic against an array-based reference model of the register file.
module tb_decode_cycle_stage;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] writedata;
    logic        regwrite;
    logic [15:0] pcout;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rdout;
    logic [15:0] imm;

    int testsRun;
    int testsFailed;

    logic [15:0] modelRf [16];
    logic [15:0] expA;
    logic [15:0] expB;
    logic [15:0] expImm;
    logic [15:0] expPc;
    logic [3:0]  expRd;

    decode_cycle_stage dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .pc        (pc),
        .writedata (writedata),
        .regwrite  (regwrite),
        .pcout     (pcout),
        .a         (a),
        .b         (b),
        .rdout     (rdout),
        .imm       (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one instruction for one edge; the model predicts the outputs
    // from the pre-edge register contents, then applies the write.
    task automatic applyStimulus(input logic [15:0] irv, input logic [15:0] pcv,
                                 input logic [15:0] wd, input logic we, input logic rstv);
        int s1, s2, d, o, hi;
        @(negedge clk);
        ir = irv; pc = pcv; writedata = wd; regwrite = we; rst = rstv;
        s2 = (irv >> 12) & 15;
        s1 = (irv >> 8) & 15;
        d  = (irv >> 4) & 15;
        o  = irv & 15;
        hi = (irv >> 8) & 255;
        if (!rstv) begin
            expA = 0; expB = 0; expImm = 0; expPc = 0; expRd = 0;
        end else begin
            expA  = modelRf[s1];
            expB  = modelRf[s2];
`ifdef DECODE_WRITE_BYPASS_EN
            if (we && d != 0 && d == s1) expA = wd;
            if (we && d != 0 && d == s2) expB = wd;
`endif
            expImm = (o == 0) ? 16'h0 : ((hi >= 128) ? 16'(hi + 65280) : 16'(hi));
            expPc  = pcv;
            expRd  = 4'(d);
        end
        @(posedge clk);
        #1;
        if (!rstv) begin
            for (int i = 0; i < 16; i++) modelRf[i] = 16'(i);
        end else if (we && d != 0) begin
            modelRf[d] = wd;
        end
    endtask

    task automatic test_reset();
        for (int n = 0; n < 4; n++) begin
            applyStimulus(16'h2160, 16'h0040, 16'(($urandom)), 1'b1, 1'b0);
            testsRun++;
            if ({a, b, imm, pcout, rdout} !== 68'h0) begin
                testsFailed++;
                $display("[TB] FAIL reset_hold edge %0d: a=%h b=%h imm=%h pcout=%h rdout=%h, want all 0",
                         n, a, b, imm, pcout, rdout);
            end
        end
    endtask

    task automatic test_decode_vectors();
        applyStimulus(16'h2160, 16'h0000, 16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h2160, 16'h0000, 16'h0000, 1'b1, 1'b1);
        testsRun++;
        if (a !== 16'd1 || b !== 16'd2 || rdout !== 4'd6 || imm !== 16'h0 || pcout !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL add_decode: a=%h b=%h rdout=%h imm=%h pcout=%h, want 1 2 6 0 0",
                     a, b, rdout, imm, pcout);
        end
        applyStimulus(16'h2165, 16'h0002, 16'h0000, 1'b1, 1'b1);
        testsRun++;
        if (imm !== 16'h0021 || pcout !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL itype_imm: imm=%h pcout=%h, want 0021 0002", imm, pcout);
        end
        applyStimulus(16'hF115, 16'h0004, 16'h0000, 1'b0, 1'b1);
        testsRun++;
        if (imm !== 16'hFFF1 || rdout !== 4'd1) begin
            testsFailed++;
            $display("[TB] FAIL sign_extend: imm=%h rdout=%h, want fff1 1", imm, rdout);
        end
    endtask

    task automatic test_write_read();
        applyStimulus(16'h0030, 16'h0010, 16'hBEEF, 1'b1, 1'b1);
        testsRun++;
        if (rdout !== 4'd3) begin
            testsFailed++;
            $display("[TB] FAIL write_rd: rdout=%h, want 3", rdout);
        end
        applyStimulus(16'h0300, 16'h0012, 16'h0000, 1'b0, 1'b1);
        testsRun++;
        if (a !== 16'hBEEF) begin
            testsFailed++;
            $display("[TB] FAIL write_then_read: a=%h, want beef", a);
        end
        applyStimulus(16'h0330, 16'h0014, 16'h1234, 1'b1, 1'b1);
        testsRun++;
`ifdef DECODE_WRITE_BYPASS_EN
        if (a !== 16'h1234) begin
            testsFailed++;
            $display("[TB] FAIL bypass_read: a=%h, want 1234", a);
        end
`else
        if (a !== 16'hBEEF) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_read: a=%h, want beef (old value)", a);
        end
`endif
        applyStimulus(16'h0300, 16'h0016, 16'h0000, 1'b0, 1'b1);
        testsRun++;
        if (a !== 16'h1234) begin
            testsFailed++;
            $display("[TB] FAIL overwrite_read: a=%h, want 1234", a);
        end
    endtask

    task automatic test_r0_write();
        applyStimulus(16'h0000, 16'h0020, 16'hFFFF, 1'b1, 1'b1);
        applyStimulus(16'h0000, 16'h0022, 16'h0000, 1'b0, 1'b1);
        testsRun++;
        if (a !== 16'h0 || b !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL r0_hardwired: a=%h b=%h, want 0 0", a, b);
        end
    endtask

    task automatic test_midop_reset();
        applyStimulus(16'h0050, 16'h0030, 16'h5A5A, 1'b1, 1'b1);
        applyStimulus(16'h0550, 16'h0032, 16'h7777, 1'b1, 1'b0);
        testsRun++;
        if ({a, b, imm, pcout, rdout} !== 68'h0) begin
            testsFailed++;
            $display("[TB] FAIL midop_reset: a=%h b=%h imm=%h pcout=%h rdout=%h, want all 0",
                     a, b, imm, pcout, rdout);
        end
        applyStimulus(16'h3500, 16'h0034, 16'h0000, 1'b0, 1'b1);
        testsRun++;
        if (a !== 16'd5 || b !== 16'd3) begin
            testsFailed++;
            $display("[TB] FAIL reload_after_reset: a=%h b=%h, want 0005 0003", a, b);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            applyStimulus(16'($urandom), 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)), 1'b1);
            testsRun++;
            if (a !== expA || b !== expB || imm !== expImm || pcout !== expPc || rdout !== expRd) begin
                testsFailed++;
                $display("[TB] FAIL random[%0d] ir=%h: got a=%h b=%h imm=%h pc=%h rd=%h, want %h %h %h %h %h",
                         n, ir, a, b, imm, pcout, rdout, expA, expB, expImm, expPc, expRd);
            end
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        rst = 1'b0; ir = '0; pc = '0; writedata = '0; regwrite = 1'b0;
        for (int i = 0; i < 16; i++) modelRf[i] = 16'(i);
        test_reset();
        test_decode_vectors();
        test_write_read();
        test_r0_write();
        test_midop_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
